scan_ctrl: RTL and testbench
============================

Name: scan_ctrl

Overview:
- Byte-command scan-chain controller for the CSoC test harness.
- Sits between uart_rx/uart_tx and the CSoC test pins, in place of hard-wired 8-bit scan handling.
- Parametrised in chain count, chain length and scan-clock rate.
- Adds per-bit shift/unload streaming, capture pulses, N-pulse functional clocking, status readback and overrun detection.

Parameters:
- N_CHAINS, 8: parallel scan chains, 1..8; one rx byte per shift cycle, bits [N_CHAINS-1:0] used.
- CHAIN_LEN, 32: shift cycles per SHIFT command, 1..65535.
- CLK_DIV, 4: system clocks per csoc_clk half-period, >=1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_ready  in  1  transmitter idle
- csoc_clk  out  1  scan/functional clock to CSoC
- csoc_rstn  out  1  CSoC reset, active low
- csoc_test_se  out  1  scan enable
- csoc_test_tm  out  1  test mode
- csoc_data_o  out  N_CHAINS  scan-in vector
- csoc_data_i  in  N_CHAINS  scan-out vector
- busy  out  1  high whenever state != IDLE

Behaviour:
Reset values:
- Async on rstn low, from any state including mid-shift: all outputs 0, so csoc_rstn=0 holds the CSoC in reset.
- Internal counters, overrun flag and state cleared.

Opcodes, taken in IDLE:
- 0x01 SET_MODE: next byte arg; tm<=arg[0], csoc_rstn<=arg[1], se unchanged. Reply 0xA5.
- 0x02 SHIFT: se<=1, then CHAIN_LEN shift cycles. After the last cycle, se<=0. No extra reply.
- 0x03 CAPTURE: se<=0, one csoc_clk pulse. Reply 0xA5.
- 0x04 PULSE: next byte n; n pulses with se=0; n=0 means 256. Reply 0xA5.
- 0x05 STATUS: reply {5'b0, overrun, csoc_rstn, tm}, then overrun is cleared.
- Any other opcode: reply 0xEE, state returns to IDLE.

Shift cycle, repeated CHAIN_LEN times:
- WAIT_RX: wait for rx_valid; csoc_data_o<=rx_data[N_CHAINS-1:0].
- LOW phase: CLK_DIV clocks with csoc_clk=0. On the last low clock, sample csoc_data_i into the out byte, zero-extended to 8 bits.
- HIGH phase: CLK_DIV clocks with csoc_clk=1, then csoc_clk returns to 0.
- TX: wait for tx_ready, then emit the out byte with a one-cycle tx_start.
- Per cycle: scan-in byte k yields scan-out byte k, the value present before clock edge k.

Pulse timing:
- Each pulse is CLK_DIV clocks low, then CLK_DIV clocks high.
- csoc_clk is 0 in IDLE and always ends low; there are no glitches and no partial pulses.

Reply path:
- State RESP waits for tx_ready.
- tx_start is asserted for exactly one cycle with tx_data stable.
- The next cycle returns to IDLE.

Overrun:
- rx_valid outside IDLE, GET_ARG or WAIT_RX drops the byte and sets the sticky overrun flag.
- Overrun is never silently absorbed as data.

Simultaneous events:
- rx_valid in the same cycle RESP completes is an overrun; IDLE is entered the next cycle.

Counters:
- Shift counter width is $clog2(CHAIN_LEN+1).
- Phase counter width is $clog2(CLK_DIV+1).
- Pulse counter is 9 bits. All wrap-free by construction.

States:
- IDLE, GET_ARG, WAIT_RX, LOW, HIGH, TX, RESP.
- Register cmd distinguishes SHIFT, CAPTURE and PULSE within LOW/HIGH.

Decomposition:
- Shared include scan_pkg.vh: opcodes, ACK=0xA5, ERR=0xEE, state encodings.
- Sub-module scan_clk_gen: CLK_DIV phase counter. Takes a start input; outputs csoc_clk, a sample strobe (last low clock) and a done strobe (end of high).
- scan_ctrl keeps the FSM, shift/pulse counters and the UART handshake.

Test Plan:
- Shift: reset, SET_MODE 0x03, SHIFT with CHAIN_LEN=4, N_CHAINS=8, bytes 0x11,0x22,0x33,0x44, CSoC model a 4-deep shift register preloaded 0xA0..0xA3 -> tx sees 0xA5 for SET_MODE, then 0xA0,0xA1,0xA2,0xA3; se high throughout; model then holds 0x11..0x44.
- Pulse count: PULSE 0x03, CLK_DIV=4 -> exactly 3 csoc_clk rising edges, each high for 4 clocks, se=0, then reply 0xA5.
- Pulse wrap: PULSE 0x00 -> 256 edges.
- Error/status: opcode 0x7F -> reply 0xEE. Byte during HIGH phase of a CAPTURE -> STATUS returns 0x04|mode bits; a second STATUS shows overrun=0.
- Backpressure: hold tx_ready low 100 clocks during a SHIFT reply -> tx_start stays low and no further csoc_clk edges occur until release; tx_start is single-cycle.
- Reset mid-op: rstn low during a HIGH phase -> csoc_clk, se, tm, csoc_rstn all 0 asynchronously, busy=0; a new SHIFT after release starts from cycle 0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared opcodes, reply codes and FSM state encoding for the byte-command
// scan-chain controller.
package scan_ctrl_pkg;

   localparam logic [7:0] OP_SET_MODE = 8'h01;
   localparam logic [7:0] OP_SHIFT    = 8'h02;
   localparam logic [7:0] OP_CAPTURE  = 8'h03;
   localparam logic [7:0] OP_PULSE    = 8'h04;
   localparam logic [7:0] OP_STATUS   = 8'h05;
   localparam logic [7:0] ACK         = 8'hA5;
   localparam logic [7:0] ERR         = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ARG,
      ST_WAIT_RX,
      ST_LOW,
      ST_HIGH,
      ST_TX,
      ST_RESP
   } state_e;

   // A pulse-count argument of zero stands for 256 pulses.
   function automatic logic [8:0] pulse_count(input logic [7:0] n);
      return (n == 8'h00) ? 9'd256 : {1'b0, n};
   endfunction

   function automatic logic rx_accepted(input state_e s);
      return (s == ST_IDLE) || (s == ST_GET_ARG) || (s == ST_WAIT_RX);
   endfunction

endpackage

// File: rtl/scan_ctrl_if.sv
// UART-side byte handshake between the host link and the scan controller.
interface scan_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready;

   modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_start);
   modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_start);
endinterface

// File: rtl/scan_ctrl_clk_gen.sv
// One csoc_clk pulse per start: CLK_DIV clocks low, then CLK_DIV clocks high,
// with strobes on the last low clock (sample) and the last high clock (done).
module scan_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic start,
   output logic csoc_clk,
   output logic sample,
   output logic done
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic             run_q, run_d;
   logic             hi_q, hi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;

   assign last     = (cnt_q == LAST_CNT);
   assign sample   = run_q && !hi_q && last;
   assign done     = run_q && hi_q && last;
   assign csoc_clk = hi_q;

   always_comb begin
      run_d = run_q;
      hi_d  = hi_q;
      cnt_d = cnt_q;
      // A start on the done clock chains the next pulse with no gap.
      if (start) begin
         run_d = 1'b1;
         hi_d  = 1'b0;
         cnt_d = '0;
      end else if (run_q) begin
         if (last) begin
            cnt_d = '0;
            hi_d  = !hi_q;
            run_d = !hi_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q <= 1'b0;
         hi_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         hi_q  <= hi_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_ctrl.sv
// Byte-command scan-chain controller: decodes UART opcodes, streams scan
// data one byte per shift cycle and drives capture/functional clock pulses.
module scan_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int N_CHAINS  = 8,
   parameter int CHAIN_LEN = 32,
   parameter int CLK_DIV   = 4
) (
   input  logic                clk,
   input  logic                rstn,
   scan_ctrl_if.slave          uart,
   output logic                csoc_clk,
   output logic                csoc_rstn,
   output logic                csoc_test_se,
   output logic                csoc_test_tm,
   output logic [N_CHAINS-1:0] csoc_data_o,
   input  logic [N_CHAINS-1:0] csoc_data_i,
   output logic                busy
);

   localparam int SC_W = $clog2(CHAIN_LEN + 1);
   localparam logic [SC_W-1:0] LAST_SHIFT = SC_W'(CHAIN_LEN - 1);

   state_e              state_q, state_d;
   logic [7:0]          cmd_q, cmd_d;
   logic                se_q, se_d;
   logic                tm_q, tm_d;
   logic                crstn_q, crstn_d;
   logic                ovr_q, ovr_d;
   logic [7:0]          reply_q, reply_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic [N_CHAINS-1:0] data_o_q, data_o_d;
   logic [SC_W-1:0]     shift_cnt_q, shift_cnt_d;
   logic [8:0]          pulse_cnt_q, pulse_cnt_d;
   logic                start, sample, done;

   scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .csoc_clk (csoc_clk),
      .sample   (sample),
      .done     (done)
   );

   assign csoc_rstn     = crstn_q;
   assign csoc_test_se  = se_q;
   assign csoc_test_tm  = tm_q;
   assign csoc_data_o   = data_o_q;
   assign uart.tx_data  = tx_data_q;
   assign uart.tx_start = tx_start_q;
   assign busy          = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      se_d        = se_q;
      tm_d        = tm_q;
      crstn_d     = crstn_q;
      ovr_d       = ovr_q;
      reply_d     = reply_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      data_o_d    = data_o_q;
      shift_cnt_d = shift_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      start       = 1'b0;

      // Bytes arriving while not listening are dropped, never used as data.
      if (uart.rx_valid && !rx_accepted(state_q)) ovr_d = 1'b1;

      unique case (state_q)
         ST_IDLE: if (uart.rx_valid) begin
            cmd_d = uart.rx_data;
            case (uart.rx_data)
               OP_SET_MODE, OP_PULSE: state_d = ST_GET_ARG;
               OP_SHIFT: begin
                  se_d        = 1'b1;
                  shift_cnt_d = '0;
                  state_d     = ST_WAIT_RX;
               end
               OP_CAPTURE: begin
                  se_d        = 1'b0;
                  pulse_cnt_d = 9'd1;
                  start       = 1'b1;
                  state_d     = ST_LOW;
               end
               OP_STATUS: begin
                  reply_d = {5'b0, ovr_q, crstn_q, tm_q};
                  ovr_d   = 1'b0;
                  state_d = ST_RESP;
               end
               default: begin
                  reply_d = ERR;
                  state_d = ST_RESP;
               end
            endcase
         end
         ST_GET_ARG: if (uart.rx_valid) begin
            if (cmd_q == OP_SET_MODE) begin
               tm_d    = uart.rx_data[0];
               crstn_d = uart.rx_data[1];
               reply_d = ACK;
               state_d = ST_RESP;
            end else begin
               se_d        = 1'b0;
               pulse_cnt_d = pulse_count(uart.rx_data);
               start       = 1'b1;
               state_d     = ST_LOW;
            end
         end
         ST_WAIT_RX: if (uart.rx_valid) begin
            data_o_d = uart.rx_data[N_CHAINS-1:0];
            start    = 1'b1;
            state_d  = ST_LOW;
         end
         ST_LOW: if (sample) begin
            if (cmd_q == OP_SHIFT) reply_d = 8'(csoc_data_i);
            state_d = ST_HIGH;
         end
         ST_HIGH: if (done) begin
            if (cmd_q == OP_SHIFT) begin
               state_d = ST_TX;
            end else if (pulse_cnt_q > 9'd1) begin
               pulse_cnt_d = pulse_cnt_q - 9'd1;
               start       = 1'b1;
               state_d     = ST_LOW;
            end else begin
               reply_d = ACK;
               state_d = ST_RESP;
            end
         end
         ST_TX: if (uart.tx_ready) begin
            tx_start_d  = 1'b1;
            tx_data_d   = reply_q;
            shift_cnt_d = shift_cnt_q + 1'b1;
            if (shift_cnt_q == LAST_SHIFT) begin
               se_d    = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_RX;
            end
         end
         ST_RESP: if (uart.tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = reply_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         se_q        <= 1'b0;
         tm_q        <= 1'b0;
         crstn_q     <= 1'b0;
         ovr_q       <= 1'b0;
         reply_q     <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         data_o_q    <= '0;
         shift_cnt_q <= '0;
         pulse_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         se_q        <= se_d;
         tm_q        <= tm_d;
         crstn_q     <= crstn_d;
         ovr_q       <= ovr_d;
         reply_q     <= reply_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         data_o_q    <= data_o_d;
         shift_cnt_q <= shift_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: a reply scoreboard, a scan-chain queue model
// and a csoc_clk pulse monitor, checked on every falling system-clock edge.
module tb_scan_ctrl;
   import scan_ctrl_pkg::*;

   localparam int N_CHAINS  = 8;
   localparam int CHAIN_LEN = 4;
   localparam int CLK_DIV   = 4;
   localparam int LIMIT     = 4000;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, busy;
   logic [N_CHAINS-1:0] csoc_data_o, csoc_data_i;

   scan_ctrl_if ifc();

   scan_ctrl #(.N_CHAINS(N_CHAINS), .CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .uart         (ifc.slave),
      .csoc_clk     (csoc_clk),
      .csoc_rstn    (csoc_rstn),
      .csoc_test_se (csoc_test_se),
      .csoc_test_tm (csoc_test_tm),
      .csoc_data_o  (csoc_data_o),
      .csoc_data_i  (csoc_data_i),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // CSoC side: four-deep scan chain, index 0 drives scan-out.
   logic [7:0] chain [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
   assign csoc_data_i = chain[0];
   always @(posedge csoc_clk) begin
      if (csoc_test_se) begin
         chain[0] <= chain[1];
         chain[1] <= chain[2];
         chain[2] <= chain[3];
         chain[3] <= csoc_data_o;
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Reference model state.
   logic [7:0] exp_q[$];
   logic [7:0] exp_chain[$] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
   logic       m_tm = 1'b0, m_rstn = 1'b0, m_ovr = 1'b0;

   // Monitor state, owned by the compare process.
   int   edges = 0, se_edges = 0, hi_run = 0, lo_run = CLK_DIV;
   logic prev_clk = 1'b0, prev_start = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         prev_clk   = 1'b0;
         prev_start = 1'b0;
         hi_run     = 0;
         lo_run     = CLK_DIV;
      end else begin
         if (ifc.tx_start) begin
            check("tx_start_width", {31'b0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL tx_unexpected: got %02h, want no transmit", ifc.tx_data);
            end else begin
               check("tx_data", {24'b0, ifc.tx_data}, {24'b0, exp_q.pop_front()});
            end
            check("mode_pins", {30'b0, csoc_test_tm, csoc_rstn}, {30'b0, m_tm, m_rstn});
         end
         if (!busy) check("idle_clk_low", {31'b0, csoc_clk}, 32'd0);
         if (csoc_clk && !prev_clk) begin
            edges++;
            if (csoc_test_se) se_edges++;
            check("clk_low_len_ok", {31'b0, lo_run >= CLK_DIV}, 32'd1);
            hi_run = 1;
         end else if (csoc_clk) begin
            hi_run++;
         end else if (prev_clk) begin
            check("clk_high_len", hi_run, CLK_DIV);
            lo_run = 1;
         end else begin
            lo_run++;
         end
         prev_clk   = csoc_clk;
         prev_start = ifc.tx_start;
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      ifc.rx_data  = b;
      ifc.rx_valid = 1'b1;
      @(negedge clk);
      ifc.rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string name);
      int n = 0;
      while (!ifc.tx_start && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) begin
         total++;
         $display("FAIL %s_timeout: got no tx_start in %0d clocks, want one", name, LIMIT);
      end
   endtask

   task automatic wait_clk_high(input string name);
      int n = 0;
      while (!csoc_clk && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         $display("FAIL %s_timeout: got csoc_clk low for 50 clocks, want high", name);
      end
   endtask

   task automatic shift_byte(input logic [7:0] b);
      exp_q.push_back(exp_chain.pop_front());
      exp_chain.push_back(b);
      send(b);
      check("shift_se", {31'b0, csoc_test_se}, 32'd1);
      wait_tx("shift");
   endtask

   initial begin
      int base, base_se, stall_starts;
      ifc.rx_data  = 8'h00;
      ifc.rx_valid = 1'b0;
      ifc.tx_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_csoc_clk", {31'b0, csoc_clk}, 32'd0);
      check("rst_csoc_rstn", {31'b0, csoc_rstn}, 32'd0);
      check("rst_se_tm", {30'b0, csoc_test_se, csoc_test_tm}, 32'd0);
      check("rst_data_o", {24'b0, csoc_data_o}, 32'd0);
      check("rst_tx", {23'b0, ifc.tx_start, ifc.tx_data}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rstn = 1'b1;

      // SET_MODE 0x03
      m_tm = 1'b1; m_rstn = 1'b1;
      exp_q.push_back(ACK);
      send(OP_SET_MODE);
      send(8'h03);
      wait_tx("set_mode");
      check("set_mode_ack", {24'b0, ifc.tx_data}, 32'hA5);

      // SHIFT 0x11..0x44 against the preloaded chain
      send(OP_SHIFT);
      for (int k = 0; k < CHAIN_LEN; k++) begin
         shift_byte(8'(8'h11 * (k + 1)));
         check("shift_out_literal", {24'b0, ifc.tx_data}, 32'hA0 + k);
      end
      @(negedge clk);
      check("shift_se_end", {31'b0, csoc_test_se}, 32'd0);
      check("shift_busy_end", {31'b0, busy}, 32'd0);
      check("chain_after", {chain[0], chain[1], chain[2], chain[3]}, 32'h11223344);

      // PULSE 3
      base = edges; base_se = se_edges;
      exp_q.push_back(ACK);
      send(OP_PULSE);
      send(8'h03);
      wait_tx("pulse3");
      check("pulse3_edges", edges - base, 3);
      check("pulse3_se_edges", se_edges - base_se, 0);

      // PULSE 0 means 256
      base = edges;
      exp_q.push_back(ACK);
      send(OP_PULSE);
      send(8'h00);
      wait_tx("pulse256");
      check("pulse256_edges", edges - base, 256);

      // Unknown opcode
      exp_q.push_back(ERR);
      send(8'h7F);
      wait_tx("bad_op");
      check("bad_op_literal", {24'b0, ifc.tx_data}, 32'hEE);

      // CAPTURE with a byte arriving during the high phase
      base = edges;
      exp_q.push_back(ACK);
      send(OP_CAPTURE);
      wait_clk_high("capture");
      send(8'h5A);
      m_ovr = 1'b1;
      wait_tx("capture");
      check("capture_edges", edges - base, 1);
      exp_q.push_back({5'b0, m_ovr, m_rstn, m_tm});
      m_ovr = 1'b0;
      send(OP_STATUS);
      wait_tx("status1");
      check("status1_literal", {24'b0, ifc.tx_data}, 32'h07);
      exp_q.push_back({5'b0, m_ovr, m_rstn, m_tm});
      send(OP_STATUS);
      wait_tx("status2");
      check("status2_literal", {24'b0, ifc.tx_data}, 32'h03);

      // SHIFT with the first reply held off by tx_ready
      send(OP_SHIFT);
      ifc.tx_ready = 1'b0;
      exp_q.push_back(exp_chain.pop_front());
      exp_chain.push_back(8'h55);
      base = edges;
      send(8'h55);
      repeat (2 * CLK_DIV + 4) @(negedge clk);
      check("bp_first_edge", edges - base, 1);
      base = edges;
      stall_starts = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ifc.tx_start) stall_starts++;
      end
      check("bp_no_tx_start", stall_starts, 0);
      check("bp_no_edges", edges - base, 0);
      ifc.tx_ready = 1'b1;
      wait_tx("bp_release");
      check("bp_out_literal", {24'b0, ifc.tx_data}, 32'h11);
      for (int k = 1; k < CHAIN_LEN; k++) shift_byte(8'(8'h55 + 8'h11 * k));

      // Asynchronous reset in the middle of a shift high phase
      send(OP_SHIFT);
      void'(exp_chain.pop_front());
      exp_chain.push_back(8'h99);
      send(8'h99);
      wait_clk_high("reset_mid");
      #2 rstn = 1'b0;
      #1;
      check("arst_csoc_clk", {31'b0, csoc_clk}, 32'd0);
      check("arst_se_tm", {30'b0, csoc_test_se, csoc_test_tm}, 32'd0);
      check("arst_csoc_rstn", {31'b0, csoc_rstn}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      m_tm = 1'b0; m_rstn = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      send(OP_SHIFT);
      for (int k = 0; k < CHAIN_LEN; k++) begin
         shift_byte(8'hC1 + 8'(k));
         check("post_rst_literal", {24'b0, ifc.tx_data}, {24'b0, 8'h66 + 8'(8'h11 * k)});
      end
      @(negedge clk);
      check("post_rst_idle", {30'b0, busy, csoc_test_se}, 32'd0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
